// File: rtl/pipe_pkg.sv
// Shared types and constants for elastic pipeline stage registers.
// Used by pipe_skid_stage and pipe_data_reg.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int          IFID_W    = 64;

endpackage

// File: rtl/pipe_data_reg.sv
// Single payload register with async reset, synchronous clear and load.
// Both reset and clear return the register to BUBBLE_DATA.
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W      = 64,
    parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BUBBLE_DATA;
        end else if (clear) begin
            q <= BUBBLE_DATA;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with 2-entry skid buffer and registered in_ready.
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                 DATA_W      = 64,
    parameter logic [DATA_W-1:0]  BUBBLE_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       stall_cycles
);

    pipe_state_e       state;
    pipe_state_e       state_next;
    logic              acc;
    logic              pop;
    logic              main_load;
    logic              main_clear;
    logic              skid_load;
    logic              skid_clear;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // In FULL the main register refills from skid; otherwise from upstream.
    assign main_d = (state == FULL) ? skid_q : in_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (flush) begin
            state_next = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        state_next = BUSY;
                        main_load  = 1'b1;
                    end
                end
                BUSY: begin
                    if (acc && pop) begin
                        main_load  = 1'b1;
                    end else if (acc) begin
                        state_next = FULL;
                        skid_load  = 1'b1;
                    end else if (pop) begin
                        state_next = EMPTY;
                        main_clear = 1'b1;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_next = BUSY;
                        main_load  = 1'b1;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_data_reg #(
        .DATA_W      (DATA_W),
        .BUBBLE_DATA (BUBBLE_DATA)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .clear (main_clear),
        .load  (main_load),
        .d     (main_d),
        .q     (out_data)
    );

    pipe_data_reg #(
        .DATA_W      (DATA_W),
        .BUBBLE_DATA (BUBBLE_DATA)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (skid_clear),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (flush) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, elastic pipeline stage register; generalises the fixed PC/instruction stage register.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds valid/ready handshake, a 2-entry skid buffer so in_ready is registered (no combinational ready path), a synchronous flush that inserts a bubble, and a configurable bubble/reset payload.

Parameters:
- DATA_W, 64, payload width in bits; the IF/ID instance packs {pc[31:0], instr[31:0]}.
- BUBBLE_DATA, '0, payload value driven on out_data whenever the stage is empty, after reset and after flush.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush; discards all held entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept a beat; a function of registered state only.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  downstream accepts a beat.
- out_data  out  DATA_W  payload to downstream; equals BUBBLE_DATA when out_valid=0.
- stall_cycles  out  32  stall counter (see Optional Feature).

Behaviour:
- Storage:
  - main register drives out_data directly.
  - skid register catches the one beat accepted while the downstream stalls.
- State machine (pipe_state_e):
  - EMPTY: main and skid both empty.
  - BUSY: main full, skid empty.
  - FULL: main and skid both full.
- Handshake signals:
  - in_ready = (state != FULL).
  - out_valid = (state != EMPTY).
- Transfer definitions:
  - acc = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Transitions, when flush=0:
  - EMPTY: acc → BUSY, main←in_data.
  - BUSY: acc & pop → BUSY, main←in_data.
  - BUSY: acc & !pop → FULL, skid←in_data.
  - BUSY: !acc & pop → EMPTY, main←BUBBLE_DATA.
  - BUSY: !acc & !pop → hold.
  - FULL: pop → BUSY, main←skid, skid←BUBBLE_DATA.
  - FULL: !pop → hold.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at edge N appears on out_data after edge N when the stage was EMPTY or popping.
  - Sustained throughput is 1 beat/cycle with out_ready held high.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- Flush:
  - flush=1 at an edge → state=EMPTY, main=skid=BUBBLE_DATA.
  - Flush takes priority over a simultaneous acc and pop. A beat offered during the flush cycle is consumed by the upstream handshake and discarded.
  - A pop in the flush cycle still counts as delivered to downstream.
- Reset:
  - rst=1 forces state=EMPTY and main=skid=BUBBLE_DATA immediately.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=BUBBLE_DATA, stall_cycles=0.
  - Reset mid-operation loses all held beats.
  - Reset takes priority over flush.
- X-safety: payload registers load only on the transitions listed above; in_data is not sampled when acc=0.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - stall_cycles is a 32-bit counter that increments on every cycle with out_valid & !out_ready.
  - It saturates at 32'hFFFF_FFFF.
  - It clears on rst and on flush.
- Undefined: stall_cycles is tied to 32'd0 and no counter flops are generated. The port list is identical in both builds.

Decomposition:
- pipe_pkg:
  - typedef enum logic [1:0] pipe_state_e {EMPTY, BUSY, FULL}.
  - localparam NOP_INSTR = 32'h0000_0013.
  - Helper constant IFID_W = 64 for the IF/ID instance.
- Sub-module pipe_data_reg:
  - One DATA_W register with async rst, load, and clear-to-BUBBLE_DATA.
  - Instantiated twice, for main and skid.
- FSM and counter live in pipe_skid_stage.

Test Plan:
1. Reset value check: apply rst with DATA_W=64, BUBBLE_DATA={32'h0, 32'h0000_0013} → out_valid=0, out_data=64'h0000_0000_0000_0013, in_ready=1, stall_cycles=0.
2. Streaming: out_ready=1, drive beats 1..16 back-to-back → each appears one cycle later, in order, with zero gaps; state never reaches FULL.
3. Downstream stall: load beat A=64'hA, drop out_ready, offer B=64'hB → B accepted, state FULL, in_ready=0, out_data=A held. Raise out_ready → A then B delivered, in_ready returns to 1 one cycle after A pops.
4. Flush priority: in FULL state holding A and B, assert flush with in_valid=1 and C=64'hC → next cycle out_valid=0, out_data=BUBBLE_DATA; A, B and C are never delivered.
5. Async reset mid-stream: assert rst between edges while in BUSY → out_valid falls without a clock edge; after release, the next beat D=64'hD is delivered normally.
6. Stall counter (PIPE_STALL_CNT_EN defined): hold out_valid=1, out_ready=0 for 7 cycles → stall_cycles=7; then flush → 0. Macro undefined → stall_cycles=0 throughout.
